// File: rtl/regfile_pkg.sv
// Shared sizing constants and index/data types for the RV64 integer register file.
package regfile_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 zero-forcing, array select and, when
// REGFILE_WRITE_BYPASS_EN is defined, same-cycle forwarding of the write port.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH,
  parameter int NR = NUM_REGS
) (
  input  logic [DW-1:0] regs [NR],
  input  logic [AW-1:0] rd_idx,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
`endif
  output logic [DW-1:0] rd_data
);

  always_comb begin
    rd_data = regs[rd_idx];
    if (rd_idx == AW'(ZERO_REG)) begin
      rd_data = '0;
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    // A pending reset wins over forwarding: the matched register is about to clear.
    else if (wr_en && (wr_idx == rd_idx)) begin
      rd_data = rst ? '0 : wr_data;
    end
`endif
  end

endmodule

// File: rtl/register_file.sv
// RV64 integer register file: 32 x 64-bit, two combinational reads, one synchronous write.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards the write port to the read ports.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // x0 is never written, so its storage stays at the reset value.
  always_comb begin
    regs_d = regs_q;
    if (regWrite && (writeRegister != ADDR_WIDTH'(ZERO_REG))) begin
      regs_d[writeRegister] = writeData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH),
    .NR (NUM_REGS)
  ) u_read_port1 (
    .regs    (regs_q),
    .rd_idx  (readRegister1),
`ifdef REGFILE_WRITE_BYPASS_EN
    .rst     (reset),
    .wr_en   (regWrite),
    .wr_idx  (writeRegister),
    .wr_data (writeData),
`endif
    .rd_data (readData1)
  );

  regfile_read_port #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH),
    .NR (NUM_REGS)
  ) u_read_port2 (
    .regs    (regs_q),
    .rd_idx  (readRegister2),
`ifdef REGFILE_WRITE_BYPASS_EN
    .rst     (reset),
    .wr_en   (regWrite),
    .wr_idx  (writeRegister),
    .wr_data (writeData),
`endif
    .rd_data (readData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: array model compared every cycle plus
// hand-computed directed expectations.
module tb_register_file;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        regWrite;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [4:0]  writeRegister;
  logic [63:0] writeData;
  logic [63:0] readData1;
  logic [63:0] readData2;

  int checks   = 0;
  int failures = 0;

  logic [63:0] model [32];
  bit          model_valid = 1'b0;

  register_file dut (
    .clock         (clock),
    .reset         (reset),
    .regWrite      (regWrite),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .readData1     (readData1),
    .readData2     (readData2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view of a read at this instant, from the register array alone.
  function automatic logic [63:0] expect_read(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
    if (BYP && regWrite && (writeRegister != 5'd0) && (idx == writeRegister))
      return reset ? 64'd0 : writeData;
    return model[idx];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) model[k] = 64'd0;
      model_valid = 1'b1;
    end else if (regWrite && (writeRegister != 5'd0)) begin
      model[writeRegister] = writeData;
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      check("model_rd1", readData1, expect_read(readRegister1));
      check("model_rd2", readData2, expect_read(readRegister2));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; regWrite = 1'b0;
    readRegister1 = 5'd0; readRegister2 = 5'd0;
    writeRegister = 5'd0; writeData = 64'd0;
    tick();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      readRegister1 = 5'(i); readRegister2 = 5'(i + 1);
      #1;
      check("reset_rd1", readData1, 64'd0);
      check("reset_rd2", readData2, 64'd0);
      tick();
    end

    for (int i = 0; i < 16; i++) begin
      regWrite = 1'b1; writeRegister = 5'(i); writeData = 64'(i + 1);
      tick();
    end
    regWrite = 1'b0;

    for (int i = 0; i < 16; i++) begin
      readRegister1 = 5'(i); readRegister2 = 5'(15 - i);
      #1;
      check("sweep_rd1", readData1, (i == 0) ? 64'd0 : 64'(i + 1));
      check("sweep_rd2", readData2, (i == 15) ? 64'd0 : 64'(16 - i));
      tick();
    end
    readRegister1 = 5'd5; readRegister2 = 5'd15;
    #1;
    check("x5_is_6", readData1, 64'd6);
    check("x15_is_16", readData2, 64'd16);

    regWrite = 1'b0; writeRegister = 5'd3; writeData = 64'hDEADBEEF_CAFEF00D;
    readRegister1 = 5'd3;
    repeat (4) tick();
    check("hold_x3", readData1, 64'd4);

    regWrite = 1'b1; writeRegister = 5'd0; writeData = 64'hFFFF_FFFF_FFFF_FFFF;
    readRegister1 = 5'd0; readRegister2 = 5'd0;
    tick();
    check("x0_rd1", readData1, 64'd0);
    check("x0_rd2", readData2, 64'd0);
    regWrite = 1'b0;

    readRegister1 = 5'd7; readRegister2 = 5'd7;
    regWrite = 1'b1; writeRegister = 5'd7; writeData = 64'h12345678;
    #1;
    check("x7_pre_rd1", readData1, BYP ? 64'h12345678 : 64'd8);
    check("x7_pre_rd2", readData2, BYP ? 64'h12345678 : 64'd8);
    tick();
    regWrite = 1'b0;
    #1;
    check("x7_post_rd1", readData1, 64'h12345678);
    check("x7_post_rd2", readData2, 64'h12345678);

    reset = 1'b1; regWrite = 1'b1; writeRegister = 5'd9; writeData = 64'hAA;
    readRegister1 = 5'd9; readRegister2 = 5'd7;
    #1;
    check("x9_pre_reset", readData1, BYP ? 64'd0 : 64'd10);
    tick();
    reset = 1'b0; regWrite = 1'b0;
    #1;
    check("x9_post_reset", readData1, 64'd0);
    check("x7_post_reset", readData2, 64'd0);
    for (int i = 0; i < 32; i++) begin
      readRegister1 = 5'(i); readRegister2 = 5'(31 - i);
      #1;
      check("clear_rd1", readData1, 64'd0);
      check("clear_rd2", readData2, 64'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
